vx_tcu_drl_norm_round: RTL
==========================

VX_TCU_DRL_NORM_ROUND -- requirements
Module: VX_tcu_drl_norm_round

Interface
REQ-001 SHALL have parameter WA, default 28: accumulator window width in bits, signed two's complement.
REQ-002 SHALL have parameter EXP_W, default 10: window exponent width; EXP_NEG_INF = {1'b1, (EXP_W-1) zeros}.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port valid_in, input, 1 bit: the input beat is valid.
REQ-006 SHALL have port ready_in, output, 1 bit: the block accepts the input beat.
REQ-007 SHALL have port acc_sig, input, WA bits: signed accumulated significand.
REQ-008 SHALL have port acc_exp, input, EXP_W bits: window exponent in the format produced by the exponent-bias stage.
REQ-009 SHALL have ports sticky_in, nan_in, inf_in and inf_sign_in, inputs, 1 bit each: sticky bit lost upstream, NaN result, infinite result, and the sign of that infinity.
REQ-010 SHALL have port valid_out, output, 1 bit; port ready_out, input, 1 bit; port result, output, 32 bits (FP32); port fflags, output, 5 bits {NV,DZ,OF,UF,NX}.

Function
REQ-011 SHALL interpret the input value as signed(acc_sig) x 2^(acc_exp - 127 - (WA-1)), with acc_exp taken as unsigned.
REQ-012 Stage 1 SHALL register sign, |acc_sig| and the leading-one position p; the most-negative acc_sig SHALL be handled as magnitude 2^(WA-1).
REQ-013 Stage 2 SHALL left-normalize the magnitude and compute the biased exponent E = acc_exp + p - (WA-1) as a signed (EXP_W+2)-bit value.
REQ-014 Stage 3 SHALL round to nearest, ties to even: 24 significand bits, then a guard bit; sticky = OR of the remaining bits OR sticky_in.
REQ-015 A rounding carry-out SHALL increment E and reset the significand to 1.0.
REQ-016 If E >= 255 after rounding, the output SHALL be the signed infinity, with OF and NX set.
REQ-017 If acc_sig == 0 or acc_exp == EXP_NEG_INF (and not nan_in or inf_in), the output SHALL be 0x00000000 and fflags SHALL be 0.
REQ-018 If nan_in is set, the output SHALL be 0x7FC00000 and fflags 0; nan_in SHALL have priority over inf_in.
REQ-019 If inf_in is set, the output SHALL be {inf_sign_in, 0x7F800000[30:0]} and fflags 0.
REQ-020 NX SHALL be set whenever guard OR sticky is 1 for a finite non-zero result; DZ and NV SHALL always be 0.
REQ-021 Latency SHALL be exactly 3 cycles from acceptance to valid_out when there is no stall.
REQ-022 stall = valid_out & ~ready_out; every stage, including valid bits, SHALL hold while stall is set; ready_in = ~stall.
REQ-023 A beat SHALL be accepted only on valid_in & ready_in; beats SHALL never be dropped, duplicated or reordered.
REQ-024 result and fflags SHALL remain stable while valid_out & ~ready_out.
REQ-025 Bubbles SHALL propagate as valid=0 and SHALL NOT be collapsed.

Reset
REQ-026 On reset, all stage valid bits and valid_out SHALL be 0 immediately (asynchronously); result and fflags SHALL be 0.
REQ-027 Reset mid-operation SHALL discard all in-flight beats; the first output after reset release SHALL come from a beat accepted after release.
REQ-028 ready_in SHALL be 1 during and after reset.

Configuration
REQ-029 With macro TCU_DRL_SUBNORM_EN defined, E <= 0 SHALL produce an FP32 subnormal: right-shift by 1-E before rounding, saturating at 25; UF SHALL be set only when the result is tiny and inexact.
REQ-030 With TCU_DRL_SUBNORM_EN undefined, E <= 0 (after rounding) SHALL produce a signed zero with UF and NX set; latency and handshake SHALL be unchanged.

Verification (WA=28)
REQ-031 acc_sig=28'h4000000, acc_exp=128 -> result 0x3F800000, fflags 0; acc_sig=28'hC000000 -> result 0xBF800000.
REQ-032 acc_exp=128, acc_sig=28'h4000004 -> result 0x3F800000 with NX set; acc_sig=28'h400000C -> result 0x3F800002 with NX set.
REQ-033 acc_sig=28'h4000000, acc_exp=300 -> result 0x7F800000 with OF and NX set; nan_in=1 -> 0x7FC00000; acc_exp=EXP_NEG_INF -> 0x00000000.
REQ-034 acc_sig=28'h4000000, acc_exp=1 -> result 0x00400000 with fflags 0 when TCU_DRL_SUBNORM_EN is defined; result 0x00000000 with UF and NX set when it is undefined.
REQ-035 Five back-to-back beats with ready_out held at 0 for 6 cycles -> ready_in drops, outputs hold stable, and all five results emerge in order with no loss.
REQ-036 Reset asserted while three beats are in flight -> valid_out is 0 in the same cycle, and no stale beat appears after release.

Source files
------------

// File: rtl/vx_tcu_drl_norm_round.sv
// vx_tcu_drl_norm_round
// Converts a signed fixed-point accumulator window (significand + window
// exponent) into an IEEE-754 binary32 result with round-to-nearest-even and
// {NV,DZ,OF,UF,NX} flags. Three register stages:
//   stage 1: sign, magnitude, leading-one position
//   stage 2: left normalization, biased exponent
//   stage 3: rounding, overflow/underflow handling, packing (output regs)
// Optional feature macro: TCU_DRL_SUBNORM_EN. When defined, results whose
// biased exponent is <= 0 are produced as binary32 subnormals; when undefined
// they flush to a signed zero with UF and NX raised.
module vx_tcu_drl_norm_round #(
   parameter int WA    = 28,
   parameter int EXP_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [WA-1:0]    acc_sig,
   input  logic [EXP_W-1:0] acc_exp,
   input  logic             sticky_in,
   input  logic             nan_in,
   input  logic             inf_in,
   input  logic             inf_sign_in,
   output logic             valid_out,
   input  logic             ready_out,
   output logic [31:0]      result,
   output logic [4:0]       fflags
);

   localparam int PW = (WA > 1) ? $clog2(WA) : 1;
   localparam int EW = EXP_W + 2;
   localparam int XW = WA + 26;

   localparam logic [EXP_W-1:0]    EXP_NEG_INF = {1'b1, {(EXP_W-1){1'b0}}};
   localparam logic [PW-1:0]       TOP_P       = PW'(WA - 1);
   localparam logic signed [EW-1:0] WA1_E      = EW'(WA - 1);
   localparam logic signed [EW-1:0] ONE_E      = EW'(1);
   localparam logic signed [EW-1:0] ZERO_E     = '0;
   localparam logic signed [EW-1:0] MAX_E      = EW'(255);
`ifdef TCU_DRL_SUBNORM_EN
   localparam logic signed [EW-1:0] NEG24_E    = EW'(-24);
`endif

   // Handshake: a beat moves on a rising edge only when its valid is high and
   // the receiver is ready. Downstream, stall = valid_out & ~ready_out freezes
   // every stage (data and valid bits) so the output word stays stable; the
   // upstream ready_in is simply ~stall, so an input beat is taken exactly on
   // valid_in & ready_in. Bubbles travel as valid=0 and are never squeezed out.
   logic stall;
   logic adv;

   assign stall    = valid_out & ~ready_out;
   assign adv      = ~stall;
   assign ready_in = ~stall;

   // ---------------- stage 1 ----------------
   logic              s1_valid_q;
   logic              s1_sign_q;
   logic [WA-1:0]     s1_mag_q;
   logic [PW-1:0]     s1_p_q;
   logic [EXP_W-1:0]  s1_exp_q;
   logic              s1_sticky_q;
   logic              s1_nan_q;
   logic              s1_inf_q;
   logic              s1_inf_sign_q;
   logic              s1_zero_q;

   logic [WA-1:0]     mag_d;
   logic [PW-1:0]     p_d;
   logic              zero_d;

   // Magnitude (most-negative input becomes 2^(WA-1) as unsigned) and MSB index.
   always_comb begin
      mag_d  = acc_sig[WA-1] ? (~acc_sig + WA'(1)) : acc_sig;
      zero_d = (acc_sig == '0) | (acc_exp == EXP_NEG_INF);
      p_d    = '0;
      for (int i = 0; i < WA; i++) begin
         if (mag_d[i]) p_d = PW'(i);
      end
   end

   // Stage 1 registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q    <= 1'b0;
         s1_sign_q     <= 1'b0;
         s1_mag_q      <= '0;
         s1_p_q        <= '0;
         s1_exp_q      <= '0;
         s1_sticky_q   <= 1'b0;
         s1_nan_q      <= 1'b0;
         s1_inf_q      <= 1'b0;
         s1_inf_sign_q <= 1'b0;
         s1_zero_q     <= 1'b0;
      end else if (adv) begin
         s1_valid_q <= valid_in;
         if (valid_in) begin
            s1_sign_q     <= acc_sig[WA-1];
            s1_mag_q      <= mag_d;
            s1_p_q        <= p_d;
            s1_exp_q      <= acc_exp;
            s1_sticky_q   <= sticky_in;
            s1_nan_q      <= nan_in;
            s1_inf_q      <= inf_in;
            s1_inf_sign_q <= inf_sign_in;
            s1_zero_q     <= zero_d;
         end
      end
   end

   // ---------------- stage 2 ----------------
   logic                 s2_valid_q;
   logic                 s2_sign_q;
   logic [WA-1:0]        s2_norm_q;
   logic signed [EW-1:0] s2_e_q;
   logic                 s2_sticky_q;
   logic                 s2_nan_q;
   logic                 s2_inf_q;
   logic                 s2_inf_sign_q;
   logic                 s2_zero_q;

   logic [WA-1:0]        norm_d;
   logic signed [EW-1:0] e_d;

   // Shift the leading one to the MSB; E = acc_exp + p - (WA-1).
   always_comb begin
      norm_d = s1_mag_q << (TOP_P - s1_p_q);
      e_d    = $signed({2'b00, s1_exp_q}) + $signed({{(EW-PW){1'b0}}, s1_p_q}) - WA1_E;
   end

   // Stage 2 registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid_q    <= 1'b0;
         s2_sign_q     <= 1'b0;
         s2_norm_q     <= '0;
         s2_e_q        <= '0;
         s2_sticky_q   <= 1'b0;
         s2_nan_q      <= 1'b0;
         s2_inf_q      <= 1'b0;
         s2_inf_sign_q <= 1'b0;
         s2_zero_q     <= 1'b0;
      end else if (adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_sign_q     <= s1_sign_q;
            s2_norm_q     <= norm_d;
            s2_e_q        <= e_d;
            s2_sticky_q   <= s1_sticky_q;
            s2_nan_q      <= s1_nan_q;
            s2_inf_q      <= s1_inf_q;
            s2_inf_sign_q <= s1_inf_sign_q;
            s2_zero_q     <= s1_zero_q;
         end
      end
   end

   // ---------------- stage 3 ----------------
   logic                 out_valid_q;
   logic [31:0]          result_q;
   logic [4:0]           fflags_q;

   logic [XW-1:0]        ext;
   logic [23:0]          mant;
   logic                 guard;
   logic                 sticky;
   logic                 inc;
   logic                 inexact;
   logic                 tiny;
   logic [24:0]          sum;
   logic signed [EW-1:0] e_r;
   logic [22:0]          frac;
   logic [31:0]          res_d;
   logic [4:0]           flags_d;
`ifdef TCU_DRL_SUBNORM_EN
   logic [4:0]           sh;
`endif

   // Round to nearest-even, then classify (special / subnormal / overflow /
   // flush / normal) and pack. The 26 zero pad bits below the window keep
   // every bit shifted out by the subnormal denormalization inside the sticky.
   always_comb begin
      ext  = {s2_norm_q, {26{1'b0}}};
      tiny = 1'b0;
`ifdef TCU_DRL_SUBNORM_EN
      sh = (s2_e_q < NEG24_E) ? 5'd25 : 5'(ONE_E - s2_e_q);
      if (s2_e_q <= ZERO_E) begin
         tiny = 1'b1;
         ext  = ext >> sh;
      end
`endif
      mant    = ext[XW-1 -: 24];
      guard   = ext[XW-25];
      sticky  = (|ext[XW-26:0]) | s2_sticky_q;
      inc     = guard & (sticky | mant[0]);
      inexact = guard | sticky;
      sum     = {1'b0, mant} + {24'd0, inc};
      // Carry-out means the significand rolled over to 2.0: bump E, frac = 0.
      e_r     = s2_e_q + (sum[24] ? ONE_E : ZERO_E);
      frac    = sum[24] ? 23'd0 : sum[22:0];

      res_d   = '0;
      flags_d = '0;
      if (s2_nan_q) begin
         res_d = 32'h7FC0_0000;
      end else if (s2_inf_q) begin
         res_d = {s2_inf_sign_q, 31'h7F80_0000};
      end else if (s2_zero_q) begin
         res_d = '0;
      end else if (tiny) begin
         // Rounding up into bit 23 naturally yields the smallest normal.
         res_d   = {s2_sign_q, 7'd0, sum[23:0]};
         flags_d = inexact ? 5'b00011 : 5'b00000;
      end else if (e_r >= MAX_E) begin
         res_d   = {s2_sign_q, 31'h7F80_0000};
         flags_d = 5'b00101;
      end else if (e_r <= ZERO_E) begin
         res_d   = {s2_sign_q, 31'd0};
         flags_d = 5'b00011;
      end else begin
         res_d   = {s2_sign_q, e_r[7:0], frac};
         flags_d = {4'd0, inexact};
      end
   end

   // Output registers; held while the consumer is not ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         fflags_q    <= '0;
      end else if (adv) begin
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            result_q <= res_d;
            fflags_q <= flags_d;
         end
      end
   end

   assign valid_out = out_valid_q;
   assign result    = result_q;
   assign fflags    = fflags_q;

endmodule
